sprite_draw_sequencer: RTL and testbench
========================================

# sprite_draw_sequencer

Parametrised object-drawing engine for the VGA path. It snapshots the position, size, colour and enable of `NUM_OBJ` on-screen objects on a `start` pulse. Optionally it first erases every object at its previous-frame position in the background colour. It then rasterises each enabled object, one pixel per cycle, onto the VGA adapter's plot interface. It sits between the game-logic position registers and the VGA adapter, and replaces the fixed five-object display datapath and its external sequencing FSM.

## Interface
- `NUM_OBJ`, 5: number of objects; index 0 is the player, 1..NUM_OBJ-1 are enemies.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `DIM_W`, 5: width/height field width.
- `COL_W`, 3: colour width.
- `BG_COLOUR`, 0: colour used in the erase pass.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to draw a frame; honoured only when idle.
- `erase_first` in 1: sampled with `start`; 1 = run the erase pass before the draw pass.
- `obj_x` in NUM_OBJ*X_W: packed top-left x; object i occupies bits [i*X_W +: X_W].
- `obj_y` in NUM_OBJ*Y_W: packed top-left y.
- `obj_w` in NUM_OBJ*DIM_W: packed widths.
- `obj_h` in NUM_OBJ*DIM_W: packed heights.
- `obj_c` in NUM_OBJ*COL_W: packed colours.
- `obj_en` in NUM_OBJ: per-object enable.
- `vga_x` out X_W: pixel x.
- `vga_y` out Y_W: pixel y.
- `vga_colour` out COL_W: pixel colour.
- `vga_plot` out 1: write strobe; pixel outputs are meaningful only while high.
- `busy` out 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` out 1: one-cycle pulse when the frame is complete.

## Operation
- States:
  - IDLE: wait for `start`.
  - LOAD: copy all `obj_*` inputs into the current snapshot.
  - SEL: select object k; skip it if disabled or w==0 or h==0.
  - PIX: raster the selected object.
  - DONE: pulse `done`.
- Pass order: the erase pass (if `erase_first`) visits objects 0..NUM_OBJ-1 using the previous snapshot and `BG_COLOUR`. The draw pass then visits 0..NUM_OBJ-1 using the current snapshot and `obj_c`.
- Raster order is row-major: col 0..w-1 inner loop, row 0..h-1 outer loop. Pixel = (x+col, y+row).
- Clipping: the sum is computed one bit wider. If x+col > 2^X_W-1 or y+row > 2^Y_W-1, the cycle is still consumed but `vga_plot`=0.
- At DONE the current snapshot is copied to the previous snapshot, so the next erase pass targets this frame's positions.
- After reset the previous snapshot is all-disabled; an erase pass then plots nothing but still spends its SEL cycles.
- Inputs may change freely after LOAD; the frame uses snapshot values only.
- `start` while busy is ignored; it is not queued.
- `reset` low mid-frame forces IDLE on the next edge:
  - all outputs go to 0;
  - the previous snapshot is cleared;
  - the partial frame is not resumed.

## Timing
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0, `busy`=0, `done`=0.
- `start` is sampled at edge 0. LOAD occupies cycle 1.
- Each object costs 1 SEL cycle, plus w*h PIX cycles if it is drawn.
- `done` is high in cycle 2 + P*NUM_OBJ + total_pixels, where P = 1 or 2 is the pass count.
- IDLE is entered the cycle after `done`, so `start` can be accepted in the very next cycle.
- `vga_plot`/`vga_x`/`vga_y`/`vga_colour` are registered from the raster counters and valid in the same cycle as the PIX state. There are no gaps between consecutive pixels of one object.
- Counter wrap: at col==w-1 the column counter resets to 0 and the row counter increments. At (w-1, h-1) the FSM goes to the next SEL, or to DONE after the last object of the draw pass.

## Structure
- Shared package `draw_pkg`:
  - state enum (IDLE, LOAD, SEL, PIX, DONE);
  - pass enum (ERASE, DRAW);
  - screen constants SCREEN_W=160, SCREEN_H=120;
  - default widths.
- Sub-module `rect_raster`:
  - loads (x, y, w, h, colour) on `go`;
  - emits one clipped pixel per cycle;
  - raises `last` on the final pixel.
- The top level holds the two snapshot register banks, the object index, the pass flag and the FSM.

## Test plan
- Reset low for 2 cycles → all outputs 0 and `busy`=0, including with `start` held high during reset.
- NUM_OBJ=5, only obj0 enabled at (10,20), 2x3, colour 4, no erase → 6 plots: (10,20),(11,20),(10,21),(11,21),(10,22),(11,22), all colour 4. `done` high at cycle 2+5+6=13.
- Frame 1 draws obj1 at (50,50) 1x1 colour 2. Frame 2 has obj1 at (51,50) with `erase_first`=1 → plot (50,50) colour 0, then (51,50) colour 2. `done` at cycle 2+10+2=14.
- Object at x=254, w=4, X_W=8 → 4 PIX cycles; plots only for x=254 and x=255.
- `start` pulsed mid-frame → ignored, with no extra `done`. Inputs changed after LOAD → drawn values match the snapshot.
- Object with w=0, and a disabled object → each costs 1 cycle with no plots. `reset` asserted during PIX → IDLE next cycle, and the next erase pass plots nothing.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and default geometry for the VGA object-drawing path.
package draw_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEL, PIX, DONE} state_e;
  typedef enum logic {ERASE, DRAW} pass_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_NUM_OBJ = 5;
  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_DIM_W   = 5;
  localparam int DEF_COL_W   = 3;

endpackage

// File: rtl/rect_raster.sv
// Rasterises one rectangle row-major, one clipped pixel per cycle; the first pixel is
// registered on the go edge, last flags the final pixel. No backpressure: always advances.
module rect_raster
  import draw_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  input  logic [COL_W-1:0] colour,
  output logic [X_W-1:0]   pixX,
  output logic [Y_W-1:0]   pixY,
  output logic [COL_W-1:0] pixColour,
  output logic             pixPlot,
  output logic             last
);

  logic [X_W-1:0]   baseX;
  logic [Y_W-1:0]   baseY;
  logic [DIM_W-1:0] lastCol, lastRow, colCnt, rowCnt;
  logic             active;

  logic [DIM_W-1:0] nextCol, nextRow, srcCol, srcRow, srcLastCol, srcLastRow;
  logic [X_W-1:0]   srcX;
  logic [Y_W-1:0]   srcY;
  logic [X_W:0]     sumX;
  logic [Y_W:0]     sumY;
  logic             emitLast;
  logic             emitOk;

  // On go the pixel comes from the new rectangle's origin, otherwise from the advanced counters.
  always_comb begin
    nextCol = colCnt + DIM_W'(1);
    nextRow = rowCnt;
    if (colCnt == lastCol) begin
      nextCol = '0;
      nextRow = rowCnt + DIM_W'(1);
    end
    if (go) begin
      srcX       = x;
      srcY       = y;
      srcCol     = '0;
      srcRow     = '0;
      srcLastCol = w - DIM_W'(1);
      srcLastRow = h - DIM_W'(1);
    end else begin
      srcX       = baseX;
      srcY       = baseY;
      srcCol     = nextCol;
      srcRow     = nextRow;
      srcLastCol = lastCol;
      srcLastRow = lastRow;
    end
    // One extra bit catches pixels falling off the coordinate range.
    sumX     = {1'b0, srcX} + (X_W+1)'(srcCol);
    sumY     = {1'b0, srcY} + (Y_W+1)'(srcRow);
    emitOk   = !sumX[X_W] && !sumY[Y_W];
    emitLast = (srcCol == srcLastCol) && (srcRow == srcLastRow);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      baseX     <= '0;
      baseY     <= '0;
      lastCol   <= '0;
      lastRow   <= '0;
      colCnt    <= '0;
      rowCnt    <= '0;
      active    <= 1'b0;
      pixX      <= '0;
      pixY      <= '0;
      pixColour <= '0;
      pixPlot   <= 1'b0;
      last      <= 1'b0;
    end else if (go) begin
      baseX     <= x;
      baseY     <= y;
      lastCol   <= srcLastCol;
      lastRow   <= srcLastRow;
      colCnt    <= '0;
      rowCnt    <= '0;
      active    <= 1'b1;
      pixX      <= sumX[X_W-1:0];
      pixY      <= sumY[Y_W-1:0];
      pixColour <= colour;
      pixPlot   <= emitOk;
      last      <= emitLast;
    end else if (active) begin
      if (last) begin
        active  <= 1'b0;
        pixPlot <= 1'b0;
        last    <= 1'b0;
      end else begin
        colCnt  <= nextCol;
        rowCnt  <= nextRow;
        pixX    <= sumX[X_W-1:0];
        pixY    <= sumY[Y_W-1:0];
        pixPlot <= emitOk;
        last    <= emitLast;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Snapshots NUM_OBJ objects on start, optionally erases last frame's positions, then draws each.
// done at cycle 2 + passes*NUM_OBJ + pixels after start; start while busy is dropped, no plot backpressure.
module sprite_draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_OBJ               = DEF_NUM_OBJ,
  parameter int X_W                   = DEF_X_W,
  parameter int Y_W                   = DEF_Y_W,
  parameter int DIM_W                 = DEF_DIM_W,
  parameter int COL_W                 = DEF_COL_W,
  parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     erase_first,
  input  logic [NUM_OBJ*X_W-1:0]   obj_x,
  input  logic [NUM_OBJ*Y_W-1:0]   obj_y,
  input  logic [NUM_OBJ*DIM_W-1:0] obj_w,
  input  logic [NUM_OBJ*DIM_W-1:0] obj_h,
  input  logic [NUM_OBJ*COL_W-1:0] obj_c,
  input  logic [NUM_OBJ-1:0]       obj_en,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  state_e           state;
  pass_e            pass;
  logic             eraseReq;
  logic [IDX_W-1:0] objIdx;

  logic [NUM_OBJ*X_W-1:0]   curX,  prevX;
  logic [NUM_OBJ*Y_W-1:0]   curY,  prevY;
  logic [NUM_OBJ*DIM_W-1:0] curW,  prevW;
  logic [NUM_OBJ*DIM_W-1:0] curH,  prevH;
  logic [NUM_OBJ*COL_W-1:0] curC;
  logic [NUM_OBJ-1:0]       curEn, prevEn;

  logic [X_W-1:0]   selX;
  logic [Y_W-1:0]   selY;
  logic [DIM_W-1:0] selW, selH;
  logic [COL_W-1:0] selC;
  logic             selEn;
  logic             drawable;
  logic             go;
  logic             rasterLast;
  logic             advance;
  logic             lastObj;

  // Erase pass reads last frame's geometry in the background colour; draw pass reads this frame.
  always_comb begin
    if (pass == ERASE) begin
      selX  = prevX[objIdx*X_W +: X_W];
      selY  = prevY[objIdx*Y_W +: Y_W];
      selW  = prevW[objIdx*DIM_W +: DIM_W];
      selH  = prevH[objIdx*DIM_W +: DIM_W];
      selC  = BG_COLOUR;
      selEn = prevEn[objIdx];
    end else begin
      selX  = curX[objIdx*X_W +: X_W];
      selY  = curY[objIdx*Y_W +: Y_W];
      selW  = curW[objIdx*DIM_W +: DIM_W];
      selH  = curH[objIdx*DIM_W +: DIM_W];
      selC  = curC[objIdx*COL_W +: COL_W];
      selEn = curEn[objIdx];
    end
    drawable = selEn && (selW != '0) && (selH != '0);
    go       = (state == SEL) && drawable;
    advance  = ((state == SEL) && !drawable) || ((state == PIX) && rasterLast);
    lastObj  = (objIdx == IDX_W'(NUM_OBJ - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pass     <= DRAW;
      eraseReq <= 1'b0;
      objIdx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      curX     <= '0;
      curY     <= '0;
      curW     <= '0;
      curH     <= '0;
      curC     <= '0;
      curEn    <= '0;
      prevX    <= '0;
      prevY    <= '0;
      prevW    <= '0;
      prevH    <= '0;
      prevEn   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            eraseReq <= erase_first;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          curX   <= obj_x;
          curY   <= obj_y;
          curW   <= obj_w;
          curH   <= obj_h;
          curC   <= obj_c;
          curEn  <= obj_en;
          objIdx <= '0;
          pass   <= eraseReq ? ERASE : DRAW;
          state  <= SEL;
        end
        SEL, PIX: begin
          if (advance) begin
            if (!lastObj) begin
              objIdx <= objIdx + IDX_W'(1);
              state  <= SEL;
            end else if (pass == ERASE) begin
              pass   <= DRAW;
              objIdx <= '0;
              state  <= SEL;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (state == SEL) begin
            state <= PIX;
          end
        end
        DONE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          prevX  <= curX;
          prevY  <= curY;
          prevW  <= curW;
          prevH  <= curH;
          prevEn <= curEn;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rect_raster #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .DIM_W (DIM_W),
    .COL_W (COL_W)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .x         (selX),
    .y         (selY),
    .w         (selW),
    .h         (selH),
    .colour    (selC),
    .pixX      (vga_x),
    .pixY      (vga_y),
    .pixColour (vga_colour),
    .pixPlot   (vga_plot),
    .last      (rasterLast)
  );

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed and random frames checked cycle by cycle against a list-of-pixels frame model.
module tb_sprite_draw_sequencer;
  import draw_pkg::*;

  localparam int N  = 5;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int DW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, start, erase_first;
  logic [N*XW-1:0] obj_x;
  logic [N*YW-1:0] obj_y;
  logic [N*DW-1:0] obj_w, obj_h;
  logic [N*CW-1:0] obj_c;
  logic [N-1:0]    obj_en;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot, busy, done;

  always #5 clk = ~clk;

  sprite_draw_sequencer #(
    .NUM_OBJ(N), .X_W(XW), .Y_W(YW), .DIM_W(DW), .COL_W(CW), .BG_COLOUR(3'd0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .erase_first(erase_first),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_c(obj_c),
    .obj_en(obj_en), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  // Input values, model's current-frame snapshot and previous-frame snapshot.
  int inX[N], inY[N], inW[N], inH[N], inC[N];
  bit inEn[N];
  int mX[N], mY[N], mW[N], mH[N], mC[N];
  bit mEn[N];
  int pX[N], pY[N], pW[N], pH[N];
  bit pEn[N];

  logic [18:0] expQ[$];
  int nChecks = 0;
  int nFail = 0;
  int dCyc, nPlots;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      obj_x[i*XW +: XW] = XW'(inX[i]);
      obj_y[i*YW +: YW] = YW'(inY[i]);
      obj_w[i*DW +: DW] = DW'(inW[i]);
      obj_h[i*DW +: DW] = DW'(inH[i]);
      obj_c[i*CW +: CW] = CW'(inC[i]);
      obj_en[i]         = inEn[i];
    end
  endtask

  task automatic clearAll();
    for (int i = 0; i < N; i++) begin
      inX[i] = 0; inY[i] = 0; inW[i] = 1; inH[i] = 1; inC[i] = 1; inEn[i] = 1'b0;
    end
  endtask

  task automatic randObj(input int k);
    inEn[k] = ($urandom_range(0, 3) != 0);
    inW[k]  = $urandom_range(0, 5);
    inH[k]  = $urandom_range(0, 5);
    inX[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, SCREEN_W - 1);
    inY[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(123, 127) : $urandom_range(0, SCREEN_H - 1);
    inC[k]  = $urandom_range(0, 7);
  endtask

  // Expected per-cycle {plot,x,y,colour} from the LOAD cycle up to the cycle before done.
  task automatic buildModel(input bit er);
    int x, y, w, h, c, sx, sy;
    bit en;
    expQ.delete();
    expQ.push_back(19'h0);
    for (int p = (er ? 0 : 1); p < 2; p++) begin
      for (int k = 0; k < N; k++) begin
        expQ.push_back(19'h0);
        if (p == 0) begin
          x = pX[k]; y = pY[k]; w = pW[k]; h = pH[k]; c = 0; en = pEn[k];
        end else begin
          x = mX[k]; y = mY[k]; w = mW[k]; h = mH[k]; c = mC[k]; en = mEn[k];
        end
        if (en && w > 0 && h > 0) begin
          for (int r = 0; r < h; r++) begin
            for (int q = 0; q < w; q++) begin
              sx = x + q;
              sy = y + r;
              if (sx < (1 << XW) && sy < (1 << YW))
                expQ.push_back({1'b1, XW'(sx), YW'(sy), CW'(c)});
              else
                expQ.push_back(19'h0);
            end
          end
        end
      end
    end
  endtask

  task automatic runFrame(input bit er, input bit midStart, input bit scramble,
                          output int doneCyc, output int plots);
    logic [20:0] obs, exp;
    int len;
    for (int k = 0; k < N; k++) begin
      mX[k] = inX[k]; mY[k] = inY[k]; mW[k] = inW[k]; mH[k] = inH[k];
      mC[k] = inC[k]; mEn[k] = inEn[k];
    end
    buildModel(er);
    len = expQ.size();
    driveInputs();
    erase_first = er;
    start = 1'b1;
    doneCyc = -1;
    plots = 0;
    for (int cyc = 1; cyc <= len; cyc++) begin
      @(negedge clk);
      obs = {done, busy, vga_plot, vga_plot ? {vga_x, vga_y, vga_colour} : 18'h0};
      exp = {1'b0, 1'b1, expQ[cyc-1]};
      check("frameCycle", 32'(obs), 32'(exp));
      if (vga_plot) plots++;
      start = midStart && (cyc == 4);
      if (scramble && cyc == 2) begin
        for (int k = 0; k < N; k++) randObj(k);
        driveInputs();
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("doneCycle", 32'({done, busy}), 32'h3);
    if (done) doneCyc = len + 1;
    @(negedge clk);
    check("idleAfterDone", 32'({done, busy, vga_plot}), 32'h0);
    if (midStart) begin
      @(negedge clk);
      check("noQueuedStart", 32'({done, busy}), 32'h0);
    end
    for (int k = 0; k < N; k++) begin
      pX[k] = mX[k]; pY[k] = mY[k]; pW[k] = mW[k]; pH[k] = mH[k]; pEn[k] = mEn[k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, timeout expected none");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b1;
    erase_first = 1'b1;
    clearAll();
    driveInputs();
    for (int k = 0; k < N; k++) pEn[k] = 1'b0;
    repeat (2) @(negedge clk);
    check("rstX", 32'(vga_x), 32'h0);
    check("rstY", 32'(vga_y), 32'h0);
    check("rstColour", 32'(vga_colour), 32'h0);
    check("rstPlot", 32'(vga_plot), 32'h0);
    check("rstBusy", 32'(busy), 32'h0);
    check("rstDone", 32'(done), 32'h0);
    reset = 1'b1;
    start = 1'b0;
    erase_first = 1'b0;
    @(negedge clk);
    check("idleAfterRst", 32'({busy, done}), 32'h0);

    // Single 2x3 object, no erase.
    clearAll();
    inEn[0] = 1'b1; inX[0] = 10; inY[0] = 20; inW[0] = 2; inH[0] = 3; inC[0] = 4;
    runFrame(1'b0, 1'b0, 1'b0, dCyc, nPlots);
    check("singleDoneCyc", 32'(dCyc), 32'd13);
    check("singlePlots", 32'(nPlots), 32'd6);

    // Move a 1x1 object and erase the old position.
    clearAll();
    inEn[1] = 1'b1; inX[1] = 50; inY[1] = 50; inC[1] = 2;
    runFrame(1'b0, 1'b0, 1'b0, dCyc, nPlots);
    inX[1] = 51;
    runFrame(1'b1, 1'b0, 1'b0, dCyc, nPlots);
    check("eraseDoneCyc", 32'(dCyc), 32'd14);
    check("erasePlots", 32'(nPlots), 32'd2);

    // Horizontal clipping at the right edge.
    clearAll();
    inEn[2] = 1'b1; inX[2] = 254; inY[2] = 5; inW[2] = 4; inH[2] = 1; inC[2] = 7;
    runFrame(1'b0, 1'b0, 1'b0, dCyc, nPlots);
    check("clipDoneCyc", 32'(dCyc), 32'd11);
    check("clipPlots", 32'(nPlots), 32'd2);

    // Start while busy and inputs changing after LOAD.
    for (int k = 0; k < N; k++) randObj(k);
    runFrame(1'b1, 1'b1, 1'b1, dCyc, nPlots);

    // Zero-width and disabled objects.
    clearAll();
    inEn[0] = 1'b1; inW[0] = 0; inH[0] = 3;
    inEn[1] = 1'b0; inW[1] = 3; inH[1] = 3;
    runFrame(1'b0, 1'b0, 1'b0, dCyc, nPlots);
    check("skipDoneCyc", 32'(dCyc), 32'd7);
    check("skipPlots", 32'(nPlots), 32'd0);

    // Reset in the middle of rastering.
    clearAll();
    inEn[0] = 1'b1; inX[0] = 0; inY[0] = 0; inW[0] = 6; inH[0] = 6; inC[0] = 5;
    driveInputs();
    erase_first = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pixBeforeRst", 32'({busy, vga_plot}), 32'h3);
    reset = 1'b0;
    @(negedge clk);
    check("midRstOutputs", 32'({vga_x, vga_y, vga_colour, vga_plot, busy, done}), 32'h0);
    reset = 1'b1;
    for (int k = 0; k < N; k++) pEn[k] = 1'b0;
    @(negedge clk);
    check("idleAfterMidRst", 32'({busy, done}), 32'h0);
    runFrame(1'b1, 1'b0, 1'b0, dCyc, nPlots);
    check("postRstDoneCyc", 32'(dCyc), 32'd48);
    check("postRstPlots", 32'(nPlots), 32'd36);

    // Random frames, back to back.
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < N; k++) randObj(k);
      runFrame(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), dCyc, nPlots);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
